// File: rtl/fifo_nibble_packer.sv
// fifo_nibble_packer
//
// Drains fixed-width entries from a show-ahead FIFO and packs them LSB-first
// into wide words. The words leave on a valid/ready stream. Storage is split
// into an accumulator and an output register, so the FIFO can be drained at one
// entry per clock while downstream keeps accepting. A flush request sends out
// whatever partial word is in the accumulator.
//
// Ports
//   clk        rising-edge clock for all logic
//   rst        synchronous, active-high reset
//   empty      FIFO empty flag
//   read_data  FIFO head entry, valid whenever empty=0 (no read latency)
//   read_en    pop request; the head entry is consumed at the edge where read_en=1
//   flush      single-cycle request to emit the current partial word
//   out_data   packed word; the first-popped entry sits in bits [DATA_W-1:0]
//   out_count  number of valid entries in out_data (1..NIBBLES)
//   out_valid  out_data/out_count are valid
//   out_ready  downstream accept; a transfer happens when out_valid && out_ready
//   busy       accumulator non-empty, word held in output, or flush in progress
//
// States
//   state    | meaning
//   ---------+----------------------------------------------------------------
//   S_FILL   | normal operation: pop entries and emit full words
//   S_FLUSH  | no pops; wait for the output register to be free, then emit the
//            | partial word (or return straight away if nothing is pending)

module fifo_nibble_packer #(
    parameter int DATA_W  = 4,
    parameter int NIBBLES = 4,
    parameter int CNT_W   = $clog2(NIBBLES + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      empty,
    input  logic [DATA_W-1:0]         read_data,
    output logic                      read_en,
    input  logic                      flush,
    output logic [DATA_W*NIBBLES-1:0] out_data,
    output logic [CNT_W-1:0]          out_count,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy
);

    localparam int WORD_W = DATA_W * NIBBLES;
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NIBBLES - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(NIBBLES);

    typedef enum logic {
        S_FILL  = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WORD_W-1:0] acc;
    logic [WORD_W-1:0] acc_nxt;
    logic [CNT_W-1:0]  acc_cnt;
    logic [CNT_W-1:0]  acc_cnt_nxt;
    logic [WORD_W-1:0] out_data_nxt;
    logic [CNT_W-1:0]  out_count_nxt;
    logic              out_valid_nxt;
    logic              out_free;
    logic              at_last;

    // The output register can take a new word this cycle if it is empty, or
    // if its current word is being accepted at this edge.
    assign out_free = !out_valid || out_ready;
    assign at_last  = (acc_cnt == LAST_SLOT);

    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        acc_cnt_nxt   = acc_cnt;
        out_data_nxt  = out_data;
        out_count_nxt = out_count;
        // A handshake clears valid. A load later in this block sets it again,
        // which lets words go out back to back with no bubble.
        out_valid_nxt = out_valid && !out_ready;
        read_en       = 1'b0;

        unique case (state)
            S_FILL: begin
                // When the final slot is waiting, pops stall until the output
                // register is free. The full word then loads straight from the
                // FIFO head and never occupies the accumulator.
                read_en = !rst && !empty && !(at_last && !out_free);
                if (read_en) begin
                    if (at_last) begin
                        out_data_nxt                    = acc;
                        out_data_nxt[WORD_W-1 -: DATA_W] = read_data;
                        out_count_nxt                   = FULL_CNT;
                        out_valid_nxt                   = 1'b1;
                        acc_nxt                         = '0;
                        acc_cnt_nxt                     = '0;
                    end else begin
                        for (int i = 0; i < NIBBLES - 1; i++) begin
                            if (acc_cnt == CNT_W'(i)) begin
                                acc_nxt[i*DATA_W +: DATA_W] = read_data;
                            end
                        end
                        acc_cnt_nxt = acc_cnt + 1'b1;
                    end
                end
                // Any pop in this cycle lands before the flush takes effect.
                // If that pop completed a word, the flush finds nothing left.
                if (flush) begin
                    state_nxt = S_FLUSH;
                end
            end

            S_FLUSH: begin
                if (acc_cnt == '0) begin
                    state_nxt = S_FILL;
                end else if (out_free) begin
                    // Slots at and above acc_cnt are always zero, because the
                    // accumulator is cleared each time it hands off a word.
                    out_data_nxt  = acc;
                    out_count_nxt = acc_cnt;
                    out_valid_nxt = 1'b1;
                    acc_nxt       = '0;
                    acc_cnt_nxt   = '0;
                    state_nxt     = S_FILL;
                end
            end

            default: begin
                state_nxt = S_FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FILL;
            acc       <= '0;
            acc_cnt   <= '0;
            out_data  <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            acc_cnt   <= acc_cnt_nxt;
            out_data  <= out_data_nxt;
            out_count <= out_count_nxt;
            out_valid <= out_valid_nxt;
        end
    end

    assign busy = (acc_cnt != '0) || out_valid || (state == S_FLUSH);

endmodule

// File: tb/tb_fifo_nibble_packer.sv
// Testbench for fifo_nibble_packer: a queue-based FIFO model feeds the DUT and
// a scoreboard predicts every output word from the entries the DUT pops.

module tb_fifo_nibble_packer;

    localparam int DATA_W  = 4;
    localparam int NIBBLES = 4;
    localparam int CNT_W   = $clog2(NIBBLES + 1);
    localparam int WORD_W  = DATA_W * NIBBLES;

    logic              clk = 1'b0;
    logic              rst;
    logic              empty;
    logic [DATA_W-1:0] read_data;
    logic              read_en;
    logic              flush;
    logic [WORD_W-1:0] out_data;
    logic [CNT_W-1:0]  out_count;
    logic              out_valid;
    logic              out_ready;
    logic              busy;

    fifo_nibble_packer #(
        .DATA_W  (DATA_W),
        .NIBBLES (NIBBLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .empty     (empty),
        .read_data (read_data),
        .read_en   (read_en),
        .flush     (flush),
        .out_data  (out_data),
        .out_count (out_count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] fifo_q[$];
    logic [DATA_W-1:0] acc_q[$];
    logic [WORD_W-1:0] exp_data[$];
    logic [CNT_W-1:0]  exp_cnt[$];
    bit                exp_flush[$];
    bit                flush_pending = 1'b0;
    int                flush_block   = 0;
    int                pushed        = 0;
    int                popped        = 0;
    bit                hold_prev     = 1'b0;
    logic [WORD_W-1:0] prev_data;
    logic [CNT_W-1:0]  prev_cnt;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit can_flush();
        return !flush_pending && (flush_block == 0);
    endfunction

    task automatic push_fifo(input logic [DATA_W-1:0] v);
        fifo_q.push_back(v);
        pushed++;
    endtask

    task automatic emit_expected(input bit is_flush);
        logic [WORD_W-1:0] w;
        w = '0;
        foreach (acc_q[i]) w[i*DATA_W +: DATA_W] = acc_q[i];
        exp_data.push_back(w);
        exp_cnt.push_back(CNT_W'(acc_q.size()));
        exp_flush.push_back(is_flush);
        acc_q.delete();
    endtask

    // Drive inputs for the coming cycle, then stop at the negative edge so
    // DUT outputs can be sampled.
    task automatic prep(input bit fl, input bit rdy);
        flush     = fl;
        out_ready = rdy;
        empty     = (fifo_q.size() == 0);
        read_data = empty ? '0 : fifo_q[0];
        @(negedge clk);
    endtask

    // Predict the effect of the coming rising edge, then advance past it.
    task automatic observe();
        if (rst) begin
            acc_q.delete();
            exp_data.delete();
            exp_cnt.delete();
            exp_flush.delete();
            flush_pending = 1'b0;
            flush_block   = 0;
            hold_prev     = 1'b0;
            return;
        end
        if (hold_prev) begin
            check_val("hold_valid", out_valid, 1);
            check_val("hold_data", out_data, prev_data);
            check_val("hold_count", out_count, prev_cnt);
        end
        hold_prev = out_valid && !out_ready;
        prev_data = out_data;
        prev_cnt  = out_count;
        if (flush_block > 0) flush_block--;
        if (out_valid && out_ready) begin
            check_val("word_expected", exp_data.size() != 0, 1);
            if (exp_data.size() != 0) begin
                check_val("word_data", out_data, exp_data.pop_front());
                check_val("word_count", out_count, exp_cnt.pop_front());
                if (exp_flush.pop_front()) flush_pending = 1'b0;
            end
        end
        if (read_en) begin
            check_val("pop_nonempty", empty, 0);
            if (!empty) begin
                acc_q.push_back(fifo_q.pop_front());
                popped++;
                if (acc_q.size() == NIBBLES) emit_expected(1'b0);
            end
        end
        if (flush && can_flush()) begin
            if (acc_q.size() > 0) begin
                emit_expected(1'b1);
                flush_pending = 1'b1;
            end else begin
                flush_block = 1;
            end
        end
    endtask

    task automatic tick();
        observe();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        empty     = 1'b1;
        read_data = '0;

        // Reset holds read_en low even though the FIFO has data.
        for (int v = 1; v <= 4; v++) push_fifo(DATA_W'(v));
        for (int k = 0; k < 2; k++) begin
            prep(0, 1);
            check_val("rst_read_en", read_en, 0);
            check_val("rst_out_valid", out_valid, 0);
            check_val("rst_out_data", out_data, 0);
            check_val("rst_out_count", out_count, 0);
            check_val("rst_busy", busy, 0);
            tick();
        end
        rst = 1'b0;

        // Basic word: 1,2,3,4 -> 16'h4321.
        for (int k = 0; k < 4; k++) begin
            prep(0, 1);
            check_val("t1_read_en", read_en, 1);
            tick();
        end
        prep(0, 1);
        check_val("t1_valid", out_valid, 1);
        check_val("t1_data", out_data, 16'h4321);
        check_val("t1_count", out_count, 4);
        tick();
        prep(0, 1);
        check_val("t1_valid_low", out_valid, 0);
        check_val("t1_busy", busy, 0);
        tick();

        // Backpressure: 1..8 with out_ready low.
        for (int v = 1; v <= 8; v++) push_fifo(DATA_W'(v));
        for (int k = 0; k < 7; k++) begin
            prep(0, 0);
            check_val("t2_read_en", read_en, 1);
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            prep(0, 0);
            check_val("t2_stall", read_en, 0);
            check_val("t2_hold_valid", out_valid, 1);
            check_val("t2_hold_data", out_data, 16'h4321);
            tick();
        end
        prep(0, 1);
        check_val("t2_release", read_en, 1);
        tick();
        prep(0, 1);
        check_val("t2_data2", out_data, 16'h8765);
        check_val("t2_count2", out_count, 4);
        tick();
        prep(0, 1);
        check_val("t2_valid_low", out_valid, 0);
        tick();

        // Partial flush: A,B -> 16'h00BA, count 2.
        push_fifo(4'hA);
        push_fifo(4'hB);
        for (int k = 0; k < 2; k++) begin
            prep(0, 1);
            tick();
        end
        prep(1, 1);
        check_val("t3_busy_acc", busy, 1);
        tick();
        prep(0, 1);
        check_val("t3_flush_read_en", read_en, 0);
        check_val("t3_flush_busy", busy, 1);
        tick();
        prep(0, 1);
        check_val("t3_valid", out_valid, 1);
        check_val("t3_data", out_data, 16'h00BA);
        check_val("t3_count", out_count, 2);
        tick();
        prep(0, 1);
        check_val("t3_busy_low", busy, 0);
        tick();

        // Flush with nothing pending.
        prep(1, 1);
        check_val("t4_idle_busy", busy, 0);
        tick();
        prep(0, 1);
        check_val("t4_flush_state_busy", busy, 1);
        check_val("t4_no_word", out_valid, 0);
        tick();
        prep(0, 1);
        check_val("t4_back_to_fill", busy, 0);
        tick();

        // Flush coinciding with the 4th pop of 5,6,7,8.
        for (int v = 5; v <= 8; v++) push_fifo(DATA_W'(v));
        for (int k = 0; k < 3; k++) begin
            prep(0, 1);
            tick();
        end
        prep(1, 1);
        check_val("t4_pop_with_flush", read_en, 1);
        tick();
        prep(0, 1);
        check_val("t4_word", out_data, 16'h8765);
        check_val("t4_word_count", out_count, 4);
        tick();
        for (int k = 0; k < 3; k++) begin
            prep(0, 1);
            check_val("t4_no_extra", out_valid, 0);
            tick();
        end

        // Reset mid-word discards 1,2,3.
        for (int v = 1; v <= 3; v++) push_fifo(DATA_W'(v));
        for (int k = 0; k < 3; k++) begin
            prep(0, 1);
            tick();
        end
        rst = 1'b1;
        prep(0, 1);
        check_val("t5_rst_read_en", read_en, 0);
        tick();
        rst = 1'b0;
        push_fifo(4'h9);
        push_fifo(4'hA);
        push_fifo(4'hB);
        push_fifo(4'hC);
        prep(0, 1);
        check_val("t5_busy_cleared", busy, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            prep(0, 1);
            tick();
        end
        prep(0, 1);
        check_val("t5_data", out_data, 16'hCBA9);
        check_val("t5_count", out_count, 4);
        tick();
        for (int k = 0; k < 2; k++) begin
            prep(0, 1);
            check_val("t5_no_stale", out_valid, 0);
            tick();
        end
        check_val("t5_sb_empty", exp_data.size(), 0);

        // Random soak.
        for (int c = 0; c < 20000; c++) begin
            if (fifo_q.size() < 12 && $urandom_range(0, 99) < 45)
                push_fifo(DATA_W'($urandom_range(0, 15)));
            if (fifo_q.size() < 12 && $urandom_range(0, 99) < 15)
                push_fifo(DATA_W'($urandom_range(0, 15)));
            prep(($urandom_range(0, 99) < 4) && can_flush(), $urandom_range(0, 99) < 70);
            tick();
        end

        // Drain everything that is left.
        guard = 0;
        while ((fifo_q.size() != 0 || acc_q.size() != 0 || exp_data.size() != 0) && guard < 500) begin
            prep((acc_q.size() != 0) && (fifo_q.size() == 0) && can_flush(), 1);
            tick();
            guard++;
        end
        check_val("drain_done", guard < 500, 1);
        check_val("all_popped", popped, pushed);
        prep(0, 1);
        tick();
        prep(0, 1);
        check_val("final_busy", busy, 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
